// File: rtl/rs_decode_pp_ram.sv
// Ping-pong codeword buffer for an RS decoder.
// Ports: CLK/RESET, write side (wr_en, wr_addr, wr_data, wr_last, wr_full),
// read side (rd_en, rd_addr, rd_done, rd_empty, q, q_valid), sticky ovf_err/udf_err.
module rs_decode_pp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 264,
  parameter int NBANK  = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_full,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              rd_empty,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam int BW = $clog2(NBANK);
  localparam int CW = BW + 1;
  localparam int MW = BW + ADDR_W;
  localparam logic [CW-1:0] CNT_FULL = CW'(NBANK);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:(1<<MW)-1];

  logic [BW-1:0]     wp_q, wp_d;
  logic [BW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, udf_q;
  logic              rd_vld_q;
  logic              rd_oob_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] q_q;
  logic              q_valid_q;

  logic wr_acc, wr_cmt, rd_acc, rd_rel;
  logic wr_in, rd_in;

  always_comb begin
    wr_full  = (cnt_q == CNT_FULL);
    rd_empty = (cnt_q == '0);
    wr_in    = ({1'b0, wr_addr} < DEPTH_L);
    rd_in    = ({1'b0, rd_addr} < DEPTH_L);
    wr_acc   = wr_en & ~wr_full & wr_in;
    wr_cmt   = wr_last & ~wr_full;
    rd_acc   = rd_en & ~rd_empty;
    rd_rel   = rd_done & ~rd_empty;
    // NBANK is a power of two, so pointer wrap is free
    wp_d     = wr_cmt ? wp_q + BW'(1) : wp_q;
    rp_d     = rd_rel ? rp_q + BW'(1) : rp_q;
    cnt_d    = cnt_q;
    unique case ({wr_cmt, rd_rel})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Array has no reset; the synchronous read samples the
  // pre-write contents on a same-edge collision.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[{wp_q, wr_addr}] <= wr_data;
    if (rd_acc) rd_data_q <= mem[{rp_q, rd_addr}];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_oob_q  <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_q | (wr_full & (wr_en | wr_last));
      udf_q     <= udf_q | (rd_empty & (rd_en | rd_done));
      rd_vld_q  <= rd_acc;
      rd_oob_q  <= rd_acc & ~rd_in;
      q_valid_q <= rd_vld_q;
      if (rd_vld_q) q_q <= rd_oob_q ? '0 : rd_data_q;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

endmodule

// File: tb/tb_rs_decode_pp_ram.sv
// Directed bench for rs_decode_pp_ram.
// Instance a: defaults (NBANK=2); instance b: NBANK=4, DATA_W=10.
module tb_rs_decode_pp_ram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic       a_wr_en, a_wr_last, a_rd_en, a_rd_done;
  logic [8:0] a_wr_addr, a_rd_addr;
  logic [7:0] a_wr_data, a_q;
  logic       a_wr_full, a_rd_empty, a_q_valid, a_ovf, a_udf;

  logic       b_wr_en, b_wr_last, b_rd_en, b_rd_done;
  logic [8:0] b_wr_addr, b_rd_addr;
  logic [9:0] b_wr_data, b_q;
  logic       b_wr_full, b_rd_empty, b_q_valid, b_ovf, b_udf;

  rs_decode_pp_ram dut_a (
    .CLK(clk), .RESET(rst_n),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_last(a_wr_last), .wr_full(a_wr_full),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_done(a_rd_done),
    .rd_empty(a_rd_empty), .q(a_q), .q_valid(a_q_valid),
    .ovf_err(a_ovf), .udf_err(a_udf)
  );

  rs_decode_pp_ram #(.DATA_W(10), .NBANK(4)) dut_b (
    .CLK(clk), .RESET(rst_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_last(b_wr_last), .wr_full(b_wr_full),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_done(b_rd_done),
    .rd_empty(b_rd_empty), .q(b_q), .q_valid(b_q_valid),
    .ovf_err(b_ovf), .udf_err(b_udf)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic write_bank_a(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 9'(i); a_wr_data = base + 8'(i);
      a_wr_last = (i == n - 1);
    end
    @(negedge clk);
    a_wr_en = 1'b0; a_wr_last = 1'b0;
  endtask

  task automatic commit_a();
    @(negedge clk); a_wr_last = 1'b1;
    @(negedge clk); a_wr_last = 1'b0;
  endtask

  task automatic release_a();
    @(negedge clk); a_rd_done = 1'b1;
    @(negedge clk); a_rd_done = 1'b0;
  endtask

  task automatic read_bank_a(input logic [7:0] base, input int n, input string nm);
    logic [7:0] exp;
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        exp = base + 8'(k - 2);
        checks++;
        if (a_q_valid !== 1'b1 || a_q !== exp) begin
          errs++;
          $display("FAIL %s[%0d]: q=%h v=%b, want q=%h v=1", nm, k - 2, a_q, a_q_valid, exp);
        end
      end
      a_rd_en = (k < n); a_rd_addr = 9'(k);
    end
  endtask

  task automatic write_bank_b(input logic [9:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b_wr_en = 1'b1; b_wr_addr = 9'(i); b_wr_data = base + 10'(i);
      b_wr_last = (i == n - 1);
    end
    @(negedge clk);
    b_wr_en = 1'b0; b_wr_last = 1'b0;
  endtask

  task automatic release_b();
    @(negedge clk); b_rd_done = 1'b1;
    @(negedge clk); b_rd_done = 1'b0;
  endtask

  task automatic read_bank_b(input logic [9:0] base, input int n, input string nm);
    logic [9:0] exp;
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        exp = base + 10'(k - 2);
        checks++;
        if (b_q_valid !== 1'b1 || b_q !== exp) begin
          errs++;
          $display("FAIL %s[%0d]: q=%h v=%b, want q=%h v=1", nm, k - 2, b_q, b_q_valid, exp);
        end
      end
      b_rd_en = (k < n); b_rd_addr = 9'(k);
    end
  endtask

  task automatic test_reset();
    a_wr_en = 0; a_wr_last = 0; a_rd_en = 0; a_rd_done = 0;
    a_wr_addr = 0; a_rd_addr = 0; a_wr_data = 0;
    b_wr_en = 0; b_wr_last = 0; b_rd_en = 0; b_rd_done = 0;
    b_wr_addr = 0; b_rd_addr = 0; b_wr_data = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_wr_full, a_rd_empty, a_q_valid, a_ovf, a_udf} !== 5'b01000) begin
      errs++;
      $display("FAIL reset_flags_a: got %b want 01000",
               {a_wr_full, a_rd_empty, a_q_valid, a_ovf, a_udf});
    end
    checks++;
    if (a_q !== 8'h00) begin
      errs++; $display("FAIL reset_q_a: got %h want 00", a_q);
    end
    checks++;
    if ({b_wr_full, b_rd_empty, b_q_valid, b_ovf, b_udf} !== 5'b01000 || b_q !== 10'h0) begin
      errs++; $display("FAIL reset_b: flags %b q %h want 01000 q 000",
                       {b_wr_full, b_rd_empty, b_q_valid, b_ovf, b_udf}, b_q);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [7:0] exp;
    for (int i = 0; i < 264; i++) begin
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 9'(i);
      a_wr_data = (i < 256) ? 8'(i) : 8'(16 + i - 256);
      a_wr_last = (i == 263);
    end
    @(negedge clk);
    a_wr_en = 1'b0; a_wr_last = 1'b0;
    checks++;
    if (a_rd_empty !== 1'b0 || a_wr_full !== 1'b0) begin
      errs++; $display("FAIL fill_commit: empty=%b full=%b want 0 0", a_rd_empty, a_wr_full);
    end
    for (int k = 0; k < 266; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (a_q_valid !== 1'b0) begin
          errs++; $display("FAIL fill_latency: q_valid=%b one cycle after rd_en, want 0", a_q_valid);
        end
      end
      if (k >= 2) begin
        exp = (k - 2 < 256) ? 8'(k - 2) : 8'(16 + k - 2 - 256);
        checks++;
        if (a_q_valid !== 1'b1 || a_q !== exp) begin
          errs++;
          $display("FAIL fill_rd[%0d]: q=%h v=%b want q=%h v=1", k - 2, a_q, a_q_valid, exp);
        end
      end
      a_rd_en = (k < 264); a_rd_addr = 9'(k);
    end
    @(negedge clk);
    checks++;
    if (a_q_valid !== 1'b0 || a_q !== 8'h17) begin
      errs++; $display("FAIL fill_hold: q=%h v=%b want q=17 v=0", a_q, a_q_valid);
    end
    // in-range then out-of-range read
    a_rd_en = 1'b1; a_rd_addr = 9'd5;
    @(negedge clk); a_rd_addr = 9'd300;
    @(negedge clk); a_rd_en = 1'b0;
    checks++;
    if (a_q !== 8'h05 || a_q_valid !== 1'b1) begin
      errs++; $display("FAIL oob_pre: q=%h v=%b want 05 1", a_q, a_q_valid);
    end
    @(negedge clk);
    checks++;
    if (a_q !== 8'h00 || a_q_valid !== 1'b1) begin
      errs++; $display("FAIL oob_rd: q=%h v=%b want 00 1", a_q, a_q_valid);
    end
    release_a();
    checks++;
    if (a_rd_empty !== 1'b1 || a_q_valid !== 1'b0) begin
      errs++; $display("FAIL fill_release: empty=%b v=%b want 1 0", a_rd_empty, a_q_valid);
    end
  endtask

  task automatic test_full();
    write_bank_a(8'hA0, 4);
    write_bank_a(8'hB0, 4);
    checks++;
    if (a_wr_full !== 1'b1 || a_ovf !== 1'b0) begin
      errs++; $display("FAIL full_set: full=%b ovf=%b want 1 0", a_wr_full, a_ovf);
    end
    @(negedge clk);
    a_wr_en = 1'b1; a_wr_addr = 9'd0; a_wr_data = 8'hFF; a_wr_last = 1'b1;
    @(negedge clk);
    a_wr_en = 1'b0; a_wr_last = 1'b0;
    checks++;
    if (a_ovf !== 1'b1 || a_wr_full !== 1'b1) begin
      errs++; $display("FAIL full_ovf: ovf=%b full=%b want 1 1", a_ovf, a_wr_full);
    end
    read_bank_a(8'hA0, 4, "full_bank0");
    release_a();
    checks++;
    if (a_wr_full !== 1'b0 || a_rd_empty !== 1'b0) begin
      errs++; $display("FAIL full_release: full=%b empty=%b want 0 0", a_wr_full, a_rd_empty);
    end
    read_bank_a(8'hB0, 4, "full_bank1");
    release_a();
    checks++;
    if (a_rd_empty !== 1'b1) begin
      errs++; $display("FAIL full_drain: empty=%b want 1", a_rd_empty);
    end
  endtask

  task automatic test_underflow();
    @(negedge clk);
    a_rd_en = 1'b1; a_rd_addr = 9'd0; a_rd_done = 1'b1;
    @(negedge clk);
    a_rd_en = 1'b0; a_rd_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (a_q_valid !== 1'b0 || a_q !== 8'hB3) begin
        errs++; $display("FAIL udf_noread[%0d]: q=%h v=%b want B3 0", k, a_q, a_q_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (a_udf !== 1'b1 || a_rd_empty !== 1'b1) begin
      errs++; $display("FAIL udf_flag: udf=%b empty=%b want 1 1", a_udf, a_rd_empty);
    end
    commit_a();
    checks++;
    if (a_wr_full !== 1'b0 || a_rd_empty !== 1'b0) begin
      errs++; $display("FAIL udf_cnt1: full=%b empty=%b want 0 0", a_wr_full, a_rd_empty);
    end
    commit_a();
    checks++;
    if (a_wr_full !== 1'b1) begin
      errs++; $display("FAIL udf_cnt2: full=%b want 1", a_wr_full);
    end
    release_a();
    release_a();
  endtask

  task automatic test_simul();
    write_bank_a(8'hC0, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 9'(i); a_wr_data = 8'hD0 + 8'(i);
      if (i == 3) begin
        a_wr_last = 1'b1; a_rd_done = 1'b1;
        a_rd_en = 1'b1; a_rd_addr = 9'd2;
      end
    end
    @(negedge clk);
    a_wr_en = 1'b0; a_wr_last = 1'b0; a_rd_done = 1'b0; a_rd_en = 1'b0;
    checks++;
    if (a_rd_empty !== 1'b0 || a_wr_full !== 1'b0) begin
      errs++; $display("FAIL simul_cnt: empty=%b full=%b want 0 0", a_rd_empty, a_wr_full);
    end
    @(negedge clk);
    checks++;
    if (a_q !== 8'hC2 || a_q_valid !== 1'b1) begin
      errs++; $display("FAIL simul_oldbank: q=%h v=%b want C2 1", a_q, a_q_valid);
    end
    read_bank_a(8'hD0, 4, "simul_rp");
    write_bank_a(8'hE0, 1);
    checks++;
    if (a_wr_full !== 1'b1) begin
      errs++; $display("FAIL simul_wp: full=%b want 1", a_wr_full);
    end
    release_a();
    read_bank_a(8'hE0, 1, "simul_wrap");
    release_a();
  endtask

  task automatic test_reset_midread();
    write_bank_a(8'h5A, 1);
    @(negedge clk);
    a_rd_en = 1'b1; a_rd_addr = 9'd0;
    @(negedge clk);
    a_rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_q !== 8'h00 || a_q_valid !== 1'b0 || a_rd_empty !== 1'b1) begin
      errs++; $display("FAIL midrst: q=%h v=%b empty=%b want 00 0 1", a_q, a_q_valid, a_rd_empty);
    end
    checks++;
    if (a_ovf !== 1'b0 || a_udf !== 1'b0) begin
      errs++; $display("FAIL midrst_err: ovf=%b udf=%b want 0 0", a_ovf, a_udf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (a_q_valid !== 1'b0 || a_q !== 8'h00) begin
        errs++; $display("FAIL midrst_after[%0d]: q=%h v=%b want 00 0", k, a_q, a_q_valid);
      end
    end
  endtask

  task automatic test_nbank4();
    write_bank_b(10'h005, 4);
    write_bank_b(10'h0F5, 4);
    write_bank_b(10'h1E5, 4);
    checks++;
    if (b_wr_full !== 1'b0) begin
      errs++; $display("FAIL nb4_3: full=%b want 0", b_wr_full);
    end
    write_bank_b(10'h2D5, 4);
    checks++;
    if (b_wr_full !== 1'b1 || b_rd_empty !== 1'b0) begin
      errs++; $display("FAIL nb4_full: full=%b empty=%b want 1 0", b_wr_full, b_rd_empty);
    end
    read_bank_b(10'h005, 4, "nb4_b0");
    release_b();
    checks++;
    if (b_wr_full !== 1'b0) begin
      errs++; $display("FAIL nb4_rel: full=%b want 0", b_wr_full);
    end
    write_bank_b(10'h3F0, 4);
    checks++;
    if (b_wr_full !== 1'b1) begin
      errs++; $display("FAIL nb4_refill: full=%b want 1", b_wr_full);
    end
    read_bank_b(10'h0F5, 4, "nb4_b1");
    release_b();
    read_bank_b(10'h1E5, 4, "nb4_b2");
    release_b();
    read_bank_b(10'h2D5, 4, "nb4_b3");
    release_b();
    read_bank_b(10'h3F0, 4, "nb4_wrap");
    release_b();
    checks++;
    if (b_rd_empty !== 1'b1 || b_ovf !== 1'b0 || b_udf !== 1'b0) begin
      errs++; $display("FAIL nb4_end: empty=%b ovf=%b udf=%b want 1 0 0", b_rd_empty, b_ovf, b_udf);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full();
    test_underflow();
    test_simul();
    test_reset_midread();
    test_nbank4();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rs_decode_pp_ram.md
RS_DECODE_PP_RAM -- requirements
Module: rs_decode_pp_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning symbol width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9, meaning symbol address width within one bank.
REQ-003 SHALL have parameter DEPTH, default 264, meaning symbols per bank; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter NBANK, default 2, meaning codeword banks; legal values 2 and 4.
REQ-005 SHALL have port CLK, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port RESET, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, meaning write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W, meaning symbol address in the current write bank.
REQ-009 SHALL have port wr_data, input, DATA_W, meaning symbol to store.
REQ-010 SHALL have port wr_last, input, 1, meaning commit the current write bank (may coincide with wr_en).
REQ-011 SHALL have port wr_full, output, 1, meaning all NBANK banks are committed and unread.
REQ-012 SHALL have port rd_en, input, 1, meaning read strobe.
REQ-013 SHALL have port rd_addr, input, ADDR_W, meaning symbol address in the current read bank.
REQ-014 SHALL have port rd_done, input, 1, meaning release the current read bank.
REQ-015 SHALL have port rd_empty, output, 1, meaning no committed bank is available.
REQ-016 SHALL have port q, output, DATA_W, meaning read data.
REQ-017 SHALL have port q_valid, output, 1, meaning q carries data for an accepted read.
REQ-018 SHALL have port ovf_err, output, 1, meaning sticky flag for a write or commit attempted while full.
REQ-019 SHALL have port udf_err, output, 1, meaning sticky flag for a read or release attempted while empty.

Function
REQ-020 SHALL store NBANK x DEPTH symbols in one memory, addressed as {bank, addr}, with no reset applied to the array contents.
REQ-021 SHALL keep a write bank pointer wp, a read bank pointer rp (both modulo NBANK) and a committed count cnt (0..NBANK).
REQ-022 SHALL accept a write when wr_en=1, wr_full=0 and wr_addr < DEPTH; the symbol is written to {wp, wr_addr} at that edge.
REQ-023 SHALL ignore a write with wr_addr >= DEPTH, with no flag raised.
REQ-024 SHALL, on wr_last=1 with wr_full=0, accept any same-cycle write into the old wp, then advance wp and increment cnt.
REQ-025 SHALL drop wr_en and wr_last while wr_full=1 and set ovf_err.
REQ-026 SHALL accept a read when rd_en=1 and rd_empty=0; it registers {rp, rd_addr} and the accept flag in cycle N+1, drives q and q_valid=1 in cycle N+2 (2-cycle latency), and pipelines fully at one read per cycle.
REQ-027 SHALL drive q to zero for an accepted read with rd_addr >= DEPTH, with q_valid still 1.
REQ-028 SHALL, for rd_en while rd_empty=1, perform no read, keep q_valid=0 and set udf_err.
REQ-029 SHALL hold q at its last value when no read data is returning; q_valid is 1 for exactly one cycle per accepted read.
REQ-030 SHALL, on rd_done=1 with cnt>0, advance rp and decrement cnt; a read accepted in the same cycle uses the old rp.
REQ-031 SHALL, on rd_done while cnt=0, take no action and set udf_err.
REQ-032 SHALL leave cnt unchanged when commit and release are both accepted in the same cycle, with both pointers advancing.
REQ-033 SHALL return the old memory contents when a read and a write hit the same address in the same cycle (read-before-write).
REQ-034 SHALL decode wr_full = (cnt == NBANK) and rd_empty = (cnt == 0) combinationally from registered state.
REQ-035 SHALL allow the write side to fill a free bank while the read side drains another (ping-pong operation).

Reset
REQ-036 SHALL, while RESET=0, immediately force wp=0, rp=0, cnt=0, q=0, q_valid=0, ovf_err=0, udf_err=0, wr_full=0, rd_empty=1, and clear the read pipeline.
REQ-037 SHALL cancel in-flight reads on a mid-operation reset, so no q_valid appears after release; committed banks are discarded.
REQ-038 SHALL clear ovf_err and udf_err only by reset.

Verification
REQ-039 SHALL cover: defaults; write 0x00..0xFF and 0x10..0x17 to addr 0..263, pulse wr_last, then read addr 0..263 -> q equals the written symbols, q_valid asserted 2 cycles after each rd_en, rd_empty=1 after rd_done.
REQ-040 SHALL cover: NBANK=2; commit 2 banks -> wr_full=1; a third wr_en/wr_last -> bank contents unchanged, ovf_err=1; rd_done -> wr_full=0.
REQ-041 SHALL cover: rd_en and rd_done with rd_empty=1 -> q_valid stays 0, udf_err=1, and cnt stays 0.
REQ-042 SHALL cover: cnt=1 with wr_last and rd_done in the same cycle -> cnt=1, wp and rp both advanced, and a same-cycle read returns old-bank data.
REQ-043 SHALL cover: RESET asserted one cycle after rd_en -> q=0, q_valid never asserts, and rd_empty=1.
REQ-044 SHALL cover: NBANK=4, DATA_W=10; 4 banks committed with distinct patterns -> read back in commit order with pointer wrap 3->0.
